// File: rtl/sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// sub_bytes_engine
//
// Sequential forward AES SubBytes unit. A 128-bit state is captured on a start
// pulse and substituted LANES bytes per clock through computed S-box lanes
// (GF(2^8) multiplicative inverse followed by the AES affine transform). The
// finished state is published on data_out together with a one-cycle done
// pulse. NB = 16/LANES substitution cycles per operation.
//
// Optional feature macro: SUB_BYTES_INV_EN
//   When defined, an extra input inv_sel selects the inverse S-box
//   (inverse affine followed by the GF(2^8) inverse) for the whole operation.
//   When undefined, only forward substitution exists and there is no inv_sel.
//
// Parameters
//   LANES  S-box lanes in parallel (1, 2, 4, 8 or 16)
//   CNT_W  batch counter width, 2**CNT_W >= 16/LANES
//
// Ports
//   clk       in   1    rising-edge clock
//   n_rst     in   1    asynchronous active-low reset
//   start     in   1    operation request, honoured in IDLE and DONE
//   data_in   in   128  input state, byte 0 = data_in[127:120]
//   inv_sel   in   1    (SUB_BYTES_INV_EN only) 1 = inverse S-box
//   busy      out  1    high while substitution batches are running
//   done      out  1    one-cycle completion pulse
//   data_out  out  128  last completed result, same byte ordering
// ---------------------------------------------------------------------------
module sub_bytes_engine #(
  parameter int LANES = 1,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] data_in,
`ifdef SUB_BYTES_INV_EN
  input  logic         inv_sel,
`endif
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  localparam int               NB       = 16 / LANES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [127:0]     r_work;
  logic [127:0]     r_data_out;
  logic [127:0]     w_work_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic [7:0]       w_in_bytes  [16];
  logic [7:0]       w_out_bytes [16];
`ifdef SUB_BYTES_INV_EN
  logic             r_inv;
`endif

  // -------------------------------------------------------------------------
  // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1 (0x11B)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^-1 = x^254 = x^2 * x^4 * ... * x^128; this also maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // b = x ^ rotl1(x) ^ rotl2(x) ^ rotl3(x) ^ rotl4(x) ^ 0x63
  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    return affine(gf_inv(x));
  endfunction

`ifdef SUB_BYTES_INV_EN
  // Inverse of the affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(inv_affine(x));
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Control: next-state logic
  // -------------------------------------------------------------------------
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);
  // A new operation may be captured from IDLE or directly from DONE.
  assign w_accept = (r_state != RUN) && start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: substitute the current batch of LANES bytes
  // -------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx         = 0;
    w_work_next = '0;
    for (int b = 0; b < 16; b++) begin
      w_in_bytes[b] = r_work[127 - 8*b -: 8];
    end
    w_out_bytes = w_in_bytes;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(r_cnt) * LANES + l;
      // The counter can exceed NB-1 only when CNT_W is wider than needed and
      // the machine is not running; never index past byte 15.
      if (idx < 16) begin
`ifdef SUB_BYTES_INV_EN
        w_out_bytes[idx[3:0]] = r_inv ? inv_sbox(w_in_bytes[idx[3:0]])
                                      : fwd_sbox(w_in_bytes[idx[3:0]]);
`else
        w_out_bytes[idx[3:0]] = fwd_sbox(w_in_bytes[idx[3:0]]);
`endif
      end
    end
    for (int b = 0; b < 16; b++) begin
      w_work_next[127 - 8*b -: 8] = w_out_bytes[b];
    end
  end

  // -------------------------------------------------------------------------
  // State, working register and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_work     <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_next;
      // Registered from next state so busy/done have no path from start.
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
      if (w_accept) begin
        r_work <= data_in;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_work <= w_work_next;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      // data_out only ever changes to a complete result.
      if (w_last) r_data_out <= w_work_next;
    end
  end

`ifdef SUB_BYTES_INV_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_inv <= inv_sel;
    end
  end
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
Sequential forward AES SubBytes unit for the encryption datapath. It pairs with the combinational invSubBytes block on the decryption side. It accepts a 128-bit state on a start pulse and substitutes LANES bytes per clock through shared, computed S-box lanes (GF(2^8) inverse followed by the affine transform). It returns the result with a one-cycle done pulse, trading latency for S-box area.

Parameters:
LANES, 1, S-box instances working in parallel; legal values 1, 2, 4, 8, 16; batches per operation NB = 16/LANES
CNT_W, 4, batch counter width; must satisfy 2^CNT_W >= NB

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request; sampled when not busy
data_in  input  128  state to substitute; byte 0 = data_in[127:120], byte 15 = data_in[7:0]
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; data_out is valid from this cycle onward
data_out  output  128  substituted state, same byte ordering as data_in

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE; busy=0; done=0; data_out=0; working register and counter cleared.
- Reset mid-operation: the operation is abandoned, no done pulse is issued, and all outputs return to reset values immediately.
- State machine: IDLE, RUN, DONE.
- IDLE: start=1 -> capture data_in into the working register, set cnt=0, go to RUN.
- RUN: busy=1. Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register are replaced by S(byte), and cnt increments. On the cycle with cnt==NB-1, the fully substituted state is written to data_out and the machine goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. If start=1 in this cycle, capture data_in and go to RUN (back-to-back operation). Otherwise go to IDLE.
- start while in RUN is ignored. data_in is only sampled on the accepting edge, so later changes to it have no effect.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NB. That is 17 cycles for LANES=1 and 2 cycles for LANES=16.
- data_out holds its value from the DONE cycle until the next completion, including through any following RUN. It never shows partial results.
- S-box: S(x) = affine(x^-1) with 0^-1 = 0; affine constant 0x63. All arithmetic is 8-bit GF(2^8) modulo 0x11B. Purely combinational inside each lane.
- busy and done are registered outputs, with no combinational path from start.

Optional Feature:
SUB_BYTES_INV_EN
- Defined: adds input port inv_sel (1 bit), sampled together with data_in on the accepting edge and held for the whole operation. inv_sel=1 makes every lane use the inverse S-box, S^-1(x) = (inv_affine(x))^-1, with the same timing. The result matches invSubBytes for all inputs.
- Not defined: no inv_sel port exists and the block performs forward substitution only.

Test Plan:
- Reset then idle: n_rst low with start toggling -> busy=0, done=0, data_out=0 throughout; no done pulse after release until start is asserted.
- All-zero state, LANES=1: start with data_in=0 -> done after exactly 17 cycles, data_out=128'h63636363636363636363636363636363; busy high for 16 cycles.
- FIPS-197 round-1 vector, LANES=1 and LANES=4: data_in=128'h193de3bea0f4e22b9ac68d2ae9f84808 -> data_out=128'hd42711aee0bf98f1b8b45de51e415230; done after 17 and 5 cycles respectively.
- Round trip against invSubBytes: data_in=128'h8dcab9bc035006bc8f57161e00cafd8d -> data_out=128'h5d7456657b536f65735b47726374545d. Feeding data_out into invSubBytes returns the original input.
- Back-to-back and ignored start: start held high continuously -> a new operation begins in each DONE cycle, one done pulse every 17 cycles, no extra pulses; a start pulse mid-RUN changes nothing.
- Reset mid-operation and inverse mode: n_rst low at cycle 8 of RUN -> no done, outputs zero. With SUB_BYTES_INV_EN defined and inv_sel=1, data_in=128'h63636363636363636363636363636363 -> data_out=0.
